// File: rtl/bc_fir_tap_line.sv
// FIR tap delay line: shifts accepted samples into a TAPS-deep window and
// presents each full window to the downstream FIR with a valid/ready handshake.
module bc_fir_tap_line #(
  parameter int N    = 8,
  parameter int TAPS = 39
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  input  logic [N-1:0] s_data,
  output logic         s_ready,
  input  logic         flush,
  output logic [N-1:0] taps [TAPS-1:0],
  output logic         m_valid,
  input  logic         m_ready,
  output logic [15:0]  win_count
);

  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic {FILL, RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic            m_valid_q, m_valid_d;
  logic [15:0]     win_count_q, win_count_d;
  logic [N-1:0]    taps_q [TAPS-1:0];
  logic [N-1:0]    taps_d [TAPS-1:0];
  logic            accept, consume;

  always_comb begin
    // In RUN the window may only move once the current one has been taken.
    s_ready     = !flush && ((state_q == FILL) || !m_valid_q || m_ready);
    accept      = s_valid && s_ready;
    consume     = m_valid_q && m_ready && !flush;
    state_d     = state_q;
    fill_d      = fill_q;
    m_valid_d   = m_valid_q;
    win_count_d = win_count_q;
    taps_d      = taps_q;

    if (consume && (win_count_q != 16'hFFFF))
      win_count_d = win_count_q + 16'd1;

    if (flush) begin
      for (int k = 0; k < TAPS; k++) taps_d[k] = '0;
      fill_d    = '0;
      state_d   = FILL;
      m_valid_d = 1'b0;
    end else begin
      if (accept) begin
        taps_d[0] = s_data;
        for (int k = 1; k < TAPS; k++) taps_d[k] = taps_q[k-1];
      end
      case (state_q)
        FILL: begin
          if (accept) begin
            if (fill_q == CW'(TAPS - 1)) begin
              state_d   = RUN;
              m_valid_d = 1'b1;
              fill_d    = '0;
            end else begin
              fill_d = fill_q + CW'(1);
            end
          end
        end
        RUN: begin
          if (accept)       m_valid_d = 1'b1;
          else if (consume) m_valid_d = 1'b0;
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      fill_q      <= '0;
      m_valid_q   <= 1'b0;
      win_count_q <= '0;
      for (int k = 0; k < TAPS; k++) taps_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      m_valid_q   <= m_valid_d;
      win_count_q <= win_count_d;
      taps_q      <= taps_d;
    end
  end

  assign taps      = taps_q;
  assign m_valid   = m_valid_q;
  assign win_count = win_count_q;

endmodule

// File: tb/tb_bc_fir_tap_line.sv
// Directed bench for bc_fir_tap_line: fill, throughput, backpressure, flush,
// reset and win_count saturation, each with hand-computed expectations.
module tb_bc_fir_tap_line;

  localparam int N    = 8;
  localparam int TAPS = 39;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic [N-1:0] s_data;
  logic         s_ready;
  logic         flush;
  logic [N-1:0] taps [TAPS-1:0];
  logic         m_valid;
  logic         m_ready;
  logic [15:0]  win_count;

  int cmp = 0;
  int err = 0;

  bc_fir_tap_line #(.N(N), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .flush(flush), .taps(taps), .m_valid(m_valid),
    .m_ready(m_ready), .win_count(win_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    // intentionally unused helper avoided; comparisons are inline per task
  endtask

  function automatic int nonzero_taps();
    int c = 0;
    for (int k = 0; k < TAPS; k++) if (taps[k] !== '0) c++;
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; flush = 1'b0; m_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    cmp++; if (m_valid !== 1'b0) begin err++; $display("FAIL reset_m_valid act=%0b exp=0", m_valid); end
    cmp++; if (win_count !== 16'd0) begin err++; $display("FAIL reset_win_count act=%0d exp=0", win_count); end
    cmp++; if (nonzero_taps() != 0) begin err++; $display("FAIL reset_taps nonzero=%0d exp=0", nonzero_taps()); end
    cmp++; if (s_ready !== 1'b1) begin err++; $display("FAIL reset_s_ready act=%0b exp=1", s_ready); end
  endtask

  // Streams count samples base+1..base+count with m_ready low; m_valid must
  // stay low until the TAPS-th sample has been accepted.
  task automatic fill_run(input string name, input int base, input int count);
    int early = 0;
    m_ready = 1'b0;
    for (int i = 1; i <= count; i++) begin
      s_valid = 1'b1; s_data = N'(base + i);
      #1;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) early++;
      tick();
    end
    s_valid = 1'b0;
    #1;
    cmp++; if (early != 0) begin err++; $display("FAIL %s_early_valid cycles=%0d exp=0", name, early); end
  endtask

  task automatic test_fill();
    fill_run("fill", 0, TAPS);
    cmp++; if (m_valid !== 1'b1) begin err++; $display("FAIL fill_m_valid act=%0b exp=1", m_valid); end
    cmp++; if (taps[0] !== 8'd39) begin err++; $display("FAIL fill_tap0 act=%0d exp=39", taps[0]); end
    cmp++; if (taps[38] !== 8'd1) begin err++; $display("FAIL fill_tap38 act=%0d exp=1", taps[38]); end
    s_valid = 1'b1; s_data = 8'd200;
    #1;
    cmp++; if (s_ready !== 1'b0) begin err++; $display("FAIL fill_s_ready_after act=%0b exp=0", s_ready); end
    s_valid = 1'b0;
  endtask

  task automatic test_throughput();
    int bad = 0;
    m_ready = 1'b1;
    for (int i = 40; i <= 49; i++) begin
      s_valid = 1'b1; s_data = N'(i);
      #1;
      if (s_ready !== 1'b1) bad++;
      tick();
      if (m_valid !== 1'b1 || taps[0] !== N'(i) || taps[1] !== N'(i - 1)) bad++;
    end
    cmp++; if (bad != 0) begin err++; $display("FAIL thru_stream bad_cycles=%0d exp=0", bad); end
    cmp++; if (win_count !== 16'd10) begin err++; $display("FAIL thru_win_count act=%0d exp=10", win_count); end
    s_valid = 1'b0;
    tick();
    cmp++; if (m_valid !== 1'b0) begin err++; $display("FAIL thru_drain_valid act=%0b exp=0", m_valid); end
    cmp++; if (win_count !== 16'd11) begin err++; $display("FAIL thru_drain_count act=%0d exp=11", win_count); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    m_ready = 1'b0; s_valid = 1'b1; s_data = 8'd50;
    tick();
    cmp++; if (m_valid !== 1'b1 || taps[0] !== 8'd50) begin err++; $display("FAIL bp_load valid=%0b tap0=%0d exp=1/50", m_valid, taps[0]); end
    s_data = 8'd51;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (s_ready !== 1'b0) bad++;
      tick();
      if (taps[0] !== 8'd50 || taps[1] !== 8'd49 || m_valid !== 1'b1) bad++;
    end
    cmp++; if (bad != 0) begin err++; $display("FAIL bp_stall bad=%0d exp=0", bad); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    cmp++; if (taps[0] !== 8'd51 || taps[1] !== 8'd50) begin err++; $display("FAIL bp_one_accept tap0=%0d tap1=%0d exp=51/50", taps[0], taps[1]); end
    cmp++; if (win_count !== 16'd12) begin err++; $display("FAIL bp_win_count act=%0d exp=12", win_count); end
    tick();
    cmp++; if (taps[0] !== 8'd51 || s_ready !== 1'b0) begin err++; $display("FAIL bp_hold tap0=%0d s_ready=%0b exp=51/0", taps[0], s_ready); end
    s_valid = 1'b0;
  endtask

  task automatic test_flush();
    flush = 1'b1; s_valid = 1'b1; s_data = 8'd77; m_ready = 1'b1;
    #1;
    cmp++; if (s_ready !== 1'b0) begin err++; $display("FAIL flush_s_ready act=%0b exp=0", s_ready); end
    tick();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    #1;
    cmp++; if (nonzero_taps() != 0) begin err++; $display("FAIL flush_taps nonzero=%0d exp=0", nonzero_taps()); end
    cmp++; if (m_valid !== 1'b0) begin err++; $display("FAIL flush_m_valid act=%0b exp=0", m_valid); end
    cmp++; if (win_count !== 16'd12) begin err++; $display("FAIL flush_win_count act=%0d exp=12", win_count); end
    cmp++; if (s_ready !== 1'b1) begin err++; $display("FAIL flush_fill_ready act=%0b exp=1", s_ready); end
    fill_run("flush_refill", 100, TAPS);
    cmp++; if (m_valid !== 1'b1 || taps[0] !== 8'd139 || taps[38] !== 8'd101) begin
      err++; $display("FAIL flush_refill valid=%0b tap0=%0d tap38=%0d exp=1/139/101", m_valid, taps[0], taps[38]);
    end
  endtask

  task automatic test_reset_midfill();
    flush = 1'b1; tick(); flush = 1'b0;
    fill_run("rst_partial", 0, 20);
    cmp++; if (taps[0] !== 8'd20) begin err++; $display("FAIL rst_partial_tap0 act=%0d exp=20", taps[0]); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    cmp++; if (nonzero_taps() != 0 || m_valid !== 1'b0 || win_count !== 16'd0) begin
      err++; $display("FAIL rst_mid nonzero=%0d valid=%0b count=%0d exp=0/0/0", nonzero_taps(), m_valid, win_count);
    end
    cmp++; if (s_ready !== 1'b1) begin err++; $display("FAIL rst_mid_s_ready act=%0b exp=1", s_ready); end
    fill_run("rst_refill", 10, TAPS - 1);
    cmp++; if (m_valid !== 1'b0) begin err++; $display("FAIL rst_refill_38 act=%0b exp=0", m_valid); end
    s_valid = 1'b1; s_data = 8'd49;
    tick();
    s_valid = 1'b0;
    cmp++; if (m_valid !== 1'b1 || taps[0] !== 8'd49 || taps[38] !== 8'd11) begin
      err++; $display("FAIL rst_refill_full valid=%0b tap0=%0d tap38=%0d exp=1/49/11", m_valid, taps[0], taps[38]);
    end
  endtask

  task automatic test_saturation();
    force dut.win_count_q = 16'hFFFD;
    #1;
    release dut.win_count_q;
    #1;
    cmp++; if (win_count !== 16'hFFFD) begin err++; $display("FAIL sat_preload act=%h exp=fffd", win_count); end
    m_ready = 1'b1; s_valid = 1'b1;
    s_data = 8'd1; tick();
    cmp++; if (win_count !== 16'hFFFE) begin err++; $display("FAIL sat_step1 act=%h exp=fffe", win_count); end
    s_data = 8'd2; tick();
    cmp++; if (win_count !== 16'hFFFF) begin err++; $display("FAIL sat_step2 act=%h exp=ffff", win_count); end
    s_data = 8'd3; tick();
    cmp++; if (win_count !== 16'hFFFF) begin err++; $display("FAIL sat_step3 act=%h exp=ffff", win_count); end
    s_valid = 1'b0; tick();
    m_ready = 1'b0;
    cmp++; if (win_count !== 16'hFFFF || m_valid !== 1'b0) begin
      err++; $display("FAIL sat_no_wrap count=%h valid=%0b exp=ffff/0", win_count, m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_throughput();
    test_backpressure();
    test_flush();
    test_reset_midfill();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
